// File: rtl/fir_stream_controller.sv
// Sequencer for one n_tap_fir: waits out coefficient load, streams a bounded sample run, captures results.
// Optional zero-sample flush of the FIR delay line is enabled by defining FIR_CTRL_FLUSH_EN.
module fir_stream_controller #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned OUT_WIDTH    = 19,
   parameter int unsigned COUNT_WIDTH  = 16,
   parameter int unsigned SETUP_CYCLES = 32,
   parameter int unsigned OUT_LATENCY  = 1,
   parameter int unsigned FLUSH_LEN    = 19
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic [COUNT_WIDTH-1:0]       sampleCount,
   input  logic                         inValid,
   input  logic signed [DATA_WIDTH-1:0] inData,
   output logic                         inReady,
   output logic                         firLoadDataFlag,
   output logic                         firStopDataLoadFlag,
   output logic signed [DATA_WIDTH-1:0] firDataIn,
   input  logic signed [OUT_WIDTH-1:0]  firDataOut,
   output logic                         outValid,
   output logic signed [OUT_WIDTH-1:0]  outData,
   output logic                         busy,
   output logic                         done
);

   localparam int unsigned CYC_MAX = (SETUP_CYCLES > FLUSH_LEN) ? SETUP_CYCLES : FLUSH_LEN;
   localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

   typedef enum logic [2:0] {
      ST_PURGE  = 3'd0,
      ST_IDLE   = 3'd1,
      ST_SETUP  = 3'd2,
      ST_STREAM = 3'd3,
`ifdef FIR_CTRL_FLUSH_EN
      ST_FLUSH  = 3'd4,
`endif
      ST_DRAIN  = 3'd5,
      ST_STOP   = 3'd6
   } state_t;

   state_t                        state, state_nxt;
   logic [CYC_W-1:0]              cyc_cnt;
   logic [COUNT_WIDTH-1:0]        remaining;
   logic [OUT_LATENCY:0]          load_line;
   logic                          ready_d, load_d, stop_d, done_d, busy_d;
   logic signed [DATA_WIDTH-1:0]  data_d;

   always_ff @(posedge clock) begin
      if (reset) state <= ST_PURGE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_PURGE:  state_nxt = ST_IDLE;
         ST_IDLE:   if (start && (sampleCount != '0)) state_nxt = ST_SETUP;
         ST_SETUP:  if (cyc_cnt == CYC_W'(SETUP_CYCLES - 1)) state_nxt = ST_STREAM;
`ifdef FIR_CTRL_FLUSH_EN
         ST_STREAM: if (inValid && (remaining == COUNT_WIDTH'(1))) state_nxt = ST_FLUSH;
         ST_FLUSH:  if (cyc_cnt == CYC_W'(FLUSH_LEN - 1)) state_nxt = ST_DRAIN;
`else
         ST_STREAM: if (inValid && (remaining == COUNT_WIDTH'(1))) state_nxt = ST_DRAIN;
`endif
         // every load has been issued; once the line empties the last result is out
         ST_DRAIN:  if (load_line == '0) state_nxt = ST_STOP;
         ST_STOP:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_PURGE;
      endcase
   end

   always_comb begin
      ready_d = 1'b0;
      load_d  = 1'b0;
      data_d  = '0;
      stop_d  = 1'b0;
      done_d  = 1'b0;
      busy_d  = 1'b0;
      ready_d = (state_nxt == ST_STREAM);
      busy_d  = (state_nxt != ST_IDLE);
      stop_d  = (state == ST_PURGE) || (state_nxt == ST_STOP);
      done_d  = (state_nxt == ST_STOP) ||
                ((state == ST_IDLE) && start && (sampleCount == '0));
      if ((state == ST_STREAM) && inValid) begin
         load_d = 1'b1;
         data_d = inData;
      end
`ifdef FIR_CTRL_FLUSH_EN
      if (state == ST_FLUSH) load_d = 1'b1;
`endif
   end

   // Shared cycle counter restarts on every state change; only SETUP and FLUSH read it.
   always_ff @(posedge clock) begin
      if (reset) begin
         cyc_cnt   <= '0;
         remaining <= '0;
      end else begin
         if (state_nxt == state) cyc_cnt <= cyc_cnt + CYC_W'(1);
         else                    cyc_cnt <= '0;
         if ((state == ST_IDLE) && start)
            remaining <= sampleCount;
         else if ((state == ST_STREAM) && inValid)
            remaining <= remaining - COUNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         inReady             <= 1'b0;
         firStopDataLoadFlag <= 1'b0;
         firDataIn           <= '0;
         load_line           <= '0;
         outValid            <= 1'b0;
         outData             <= '0;
         busy                <= 1'b0;
         done                <= 1'b0;
      end else begin
         inReady             <= ready_d;
         firStopDataLoadFlag <= stop_d;
         firDataIn           <= data_d;
         load_line           <= {load_line[OUT_LATENCY-1:0], load_d};
         outValid            <= load_line[OUT_LATENCY];
         if (load_line[OUT_LATENCY]) outData <= firDataOut;
         busy                <= busy_d;
         done                <= done_d;
      end
   end

   // Stage 0 of the result tracking line is the load strobe itself.
   assign firLoadDataFlag = load_line[0];

endmodule
